// File: rtl/learn_pkg.sv
// Shared Learn-mode definitions: sequencer states, note word layout and the
// bit-reversed note packing used by the song ROM builder and play logic.
package learn_pkg;

  localparam int NOTE_W = 10;
  localparam logic [NOTE_W-1:0] EOS_WORD = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_D,
    PRESENT,
    RELEASE,
    DONE
  } state_t;

  // Note word is {buts[0], buts[1], ..., buts[7], octave[1:0]}
  function automatic logic [NOTE_W-1:0] pack_note(input logic [7:0] buts,
                                                  input logic [1:0] octave);
    logic [7:0] rev;
    for (int i = 0; i < 8; i++) rev[i] = buts[7-i];
    return {rev, octave};
  endfunction

  function automatic logic [7:0] unpack_buts(input logic [NOTE_W-1:0] note);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = note[NOTE_W-1-i];
    return b;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Per-note timeout counter: cleared when a note is loaded, counts while
// enabled and holds at the terminal count, flagging expire there.
module note_timer #(
  parameter int TMR_W       = 27,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TMR_W-1:0] count_reg;

  assign expire = (count_reg == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/learn_sequencer.sv
// Learn-mode sequencer: fetches song notes, shows hints, scores matching key
// presses. Define LEARN_TIMEOUT_EN to enable the per-note miss timer.
module learn_sequencer
  import learn_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int TMR_W       = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        buts,
  input  logic [1:0]        octave,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NOTE_W-1:0] mem_data,
  output logic [7:0]        hint_buts,
  output logic [1:0]        hint_octave,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic              miss,
  output logic [7:0]        score
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [NOTE_W-1:0] note_reg, note_next;
  logic [7:0]        score_reg;
  logic [7:0]        hint_buts_reg;
  logic [1:0]        hint_octave_reg;
  logic              hit_reg, hit_next;
  logic              miss_reg, miss_next;
  logic              start_accept;
  logic              match;
  logic              expire;

  assign match = (buts != 8'h00) && (pack_note(buts, octave) == note_reg);

`ifdef LEARN_TIMEOUT_EN
  note_timer #(
    .TMR_W      (TMR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_note_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_reg == WAIT_D),
    .enable(state_reg == PRESENT),
    .expire(expire)
  );
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{TMR_W, TIMEOUT_CYC};
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    start_accept = 1'b0;
    note_next    = (state_reg == WAIT_D) ? mem_data : note_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          start_accept = 1'b1;
          addr_next    = '0;
          state_next   = FETCH;
        end
      end
      FETCH:   state_next = WAIT_D;
      WAIT_D:  state_next = (mem_data == EOS_WORD) ? DONE : PRESENT;
      PRESENT: begin
        // A match in the expiry cycle still counts as a hit
        if (match) begin
          hit_next   = 1'b1;
          state_next = RELEASE;
        end else if (expire) begin
          miss_next  = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (buts == 8'h00) begin
          if (addr_reg == ADDR_LAST) begin
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      note_reg        <= '0;
      score_reg       <= '0;
      hint_buts_reg   <= '0;
      hint_octave_reg <= '0;
      hit_reg         <= 1'b0;
      miss_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      note_reg  <= note_next;
      hit_reg   <= hit_next;
      miss_reg  <= miss_next;
      if (start_accept) begin
        score_reg <= '0;
      end else if (hit_next && score_reg != 8'hFF) begin
        score_reg <= score_reg + 1'b1;
      end
      if (state_next == PRESENT) begin
        hint_buts_reg   <= unpack_buts(note_next);
        hint_octave_reg <= note_next[1:0];
      end else begin
        hint_buts_reg   <= '0;
        hint_octave_reg <= '0;
      end
    end
  end

  assign mem_rd      = (state_reg == FETCH);
  assign mem_addr    = addr_reg;
  assign hint_buts   = hint_buts_reg;
  assign hint_octave = hint_octave_reg;
  assign busy        = (state_reg != IDLE) && (state_reg != DONE);
  assign done        = (state_reg == DONE);
  assign hit         = hit_reg;
  assign miss        = miss_reg;
  assign score       = score_reg;

endmodule

// File: tb/tb_learn_sequencer.sv
// Self-checking bench for learn_sequencer: ROM model, hit scoreboard queue,
// directed Learn-mode scenarios; timeout checks follow LEARN_TIMEOUT_EN.
module tb_learn_sequencer;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        buts = 8'h00;
  logic [1:0]        octave = 2'd0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [9:0]        mem_data = 10'h000;
  logic [7:0]        hint_buts;
  logic [1:0]        hint_octave;
  logic              busy, done, hit, miss;
  logic [7:0]        score;

  logic [9:0] rom [0:255];

  int errors = 0;
  int checks = 0;
  int exp_score = 0;
  int exp_q[$];
  int hits_seen = 0;
  int miss_seen = 0;

  learn_sequencer #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(16),
    .TMR_W      (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .buts       (buts),
    .octave     (octave),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .hint_buts  (hint_buts),
    .hint_octave(hint_octave),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .miss       (miss),
    .score      (score)
  );

  always #5 clk = ~clk;

  // Song ROM with one-cycle registered read
  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

  function automatic logic [9:0] pk(input logic [7:0] b, input logic [1:0] o);
    logic [9:0] w;
    w[1:0] = o;
    for (int k = 0; k < 8; k++) w[9-k] = b[k];
    return w;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    int e;
    if (rst_n) begin
      if (hit) begin
        hits_seen++;
        if (exp_q.size() == 0) begin
          check("hit_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("hit_score", int'(score), e);
        end
        $display("hit t=%0t addr=%0d score=%0d", $time, mem_addr, score);
      end
      if (miss) begin
        miss_seen++;
        $display("miss t=%0t addr=%0d score=%0d", $time, mem_addr, score);
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 10'h000;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_song();
    exp_score = 0;
    pulse_start();
  endtask

  task automatic wait_hint(input string tag);
    int n;
    n = 0;
    while (hint_buts == 8'h00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (hint_buts == 8'h00) check({tag, "_hint_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, int'(done), 1);
  endtask

  // Press at a negedge in PRESENT; hit must appear one cycle later
  task automatic press(input logic [7:0] b, input logic [1:0] o, input bit rel);
    buts = b;
    octave = o;
    exp_score = (exp_score >= 255) ? 255 : exp_score + 1;
    exp_q.push_back(exp_score);
    @(negedge clk);
    check("hit_latency", int'(hit), 1);
    if (rel) buts = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0;
    int n;
    clear_rom();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_score", int'(score), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_hint", int'({hint_buts, hint_octave}), 0);
    check("rst_rd", int'(mem_rd), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-note song with EOS, latency checks
    rom[0] = pk(8'h01, 2'd1);
    rom[1] = pk(8'h04, 2'd2);
    rom[2] = 10'h000;
    begin_song();
    check("t1_rd", int'(mem_rd), 1);
    check("t1_busy", int'(busy), 1);
    check("t1_addr", int'(mem_addr), 0);
    @(negedge clk);
    check("t1_rd_pulse", int'(mem_rd), 0);
    check("t1_hint_early", int'(hint_buts), 0);
    @(negedge clk);
    check("t1_hint_buts0", int'(hint_buts), 8'h01);
    check("t1_hint_oct0", int'(hint_octave), 1);
    press(8'h01, 2'd1, 1'b1);
    wait_hint("t1");
    check("t1_hint_buts1", int'(hint_buts), 8'h04);
    check("t1_hint_oct1", int'(hint_octave), 2);
    press(8'h04, 2'd2, 1'b1);
    wait_done("t1");
    check("t1_score", int'(score), 2);
    check("t1_addr_end", int'(mem_addr), 2);
    check("t1_busy_end", int'(busy), 0);
    check("t1_hint_end", int'({hint_buts, hint_octave}), 0);
    check("t1_queue", exp_q.size(), 0);

    // Wrong octave / extra key is ignored
    clear_rom();
    rom[0] = pk(8'h02, 2'd0);
    begin_song();
    wait_hint("t2");
    h0 = hits_seen;
    buts = 8'h02;
    octave = 2'd3;
    repeat (10) @(negedge clk);
    check("t2_hint_buts", int'(hint_buts), 8'h02);
    check("t2_hint_oct", int'(hint_octave), 0);
    check("t2_busy", int'(busy), 1);
    check("t2_score", int'(score), 0);
    buts = 8'h03;
    octave = 2'd0;
    repeat (5) @(negedge clk);
    check("t2_nohit", hits_seen - h0, 0);
    press(8'h02, 2'd0, 1'b1);
    wait_done("t2");
    check("t2_score_end", int'(score), 1);

    // Held chord must not score consecutive equal notes
    rom[0] = pk(8'h10, 2'd2);
    rom[1] = pk(8'h10, 2'd2);
    rom[2] = 10'h000;
    begin_song();
    wait_hint("t3");
    h0 = hits_seen;
    press(8'h10, 2'd2, 1'b0);
    repeat (10) @(negedge clk);
    check("t3_one_hit", hits_seen - h0, 1);
    check("t3_hold_hint", int'(hint_buts), 0);
    check("t3_hold_addr", int'(mem_addr), 0);
    buts = 8'h00;
    wait_hint("t3b");
    check("t3_addr1", int'(mem_addr), 1);
    press(8'h10, 2'd2, 1'b1);
    wait_done("t3");
    check("t3_score", int'(score), 2);

    // Timeout behaviour
    clear_rom();
    rom[0] = pk(8'h20, 2'd1);
    begin_song();
    wait_hint("t4");
`ifdef LEARN_TIMEOUT_EN
    n = 0;
    while (!miss && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_miss_delay", n, 16);
    check("t4_score", int'(score), 0);
    wait_done("t4");
    check("t4_miss_count", miss_seen, 1);
`else
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      n++;
    end
    check("t4_no_miss", miss_seen, 0);
    check("t4_still_hint", int'(hint_buts), 8'h20);
    check("t4_still_busy", int'(busy), n == 1000 ? 1 : 0);
    press(8'h20, 2'd1, 1'b1);
    wait_done("t4");
`endif
    check("t4_score_end", int'(score), exp_score);

    // Start during busy ignored; async reset mid-PRESENT
    rom[0] = pk(8'h01, 2'd0);
    rom[1] = pk(8'h02, 2'd0);
    begin_song();
    wait_hint("t5");
    press(8'h01, 2'd0, 1'b1);
    wait_hint("t5b");
    pulse_start();
    check("t5_start_addr", int'(mem_addr), 1);
    check("t5_start_hint", int'(hint_buts), 8'h02);
    check("t5_start_score", int'(score), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_hint", int'({hint_buts, hint_octave}), 0);
    check("t5_rst_score", int'(score), 0);
    check("t5_rst_addr", int'(mem_addr), 0);
    exp_q.delete();
    exp_score = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle", int'(busy), 0);

    // Full address space without EOS; score saturates at 255
    for (int i = 0; i < 256; i++) rom[i] = pk(8'h01 << (i % 8), 2'(i % 4));
    h0 = hits_seen;
    begin_song();
    for (int i = 0; i < 256; i++) begin
      wait_hint("t6");
      check("t6_hint", int'({hint_buts, hint_octave}),
            int'({8'(8'h01 << (i % 8)), 2'(i % 4)}));
      press(8'h01 << (i % 8), 2'(i % 4), 1'b1);
    end
    wait_done("t6");
    check("t6_hits", hits_seen - h0, 256);
    check("t6_score", int'(score), 255);
    check("t6_addr", int'(mem_addr), 255);
    check("t6_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
